// File: rtl/mul_unit_if.sv
// Handshake and result bus between the multiply requester and mul_unit.
// The master issues operands and start; the slave (the multiplier) returns
// busy/done, the product words and the N/Z flags.
interface mul_unit_if;
  logic        start;
  logic        is_long;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        flag_n;
  logic        flag_z;

  modport master (
    output start, is_long, is_signed, a, b,
    input  busy, done, result_lo, result_hi, flag_n, flag_z
  );

  modport slave (
    input  start, is_long, is_signed, a, b,
    output busy, done, result_lo, result_hi, flag_n, flag_z
  );
endinterface

// File: rtl/mul_unit.sv
// Iterative 32x32 multiplier: one radix-2 shift-add step per cycle over
// 32 cycles. It works on operand magnitudes and negates the 64-bit product
// at the end when a signed long multiply has operands of opposite sign.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | 32 shift-add iterations, busy high
// DONE  | one cycle, done high and results valid; start here is accepted
module mul_unit (
  input  logic        clk,
  input  logic        reset,
  mul_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [5:0]  count;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic        long_q;
  logic        neg_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] lo_q;
  logic [31:0] hi_q;
  logic        n_q;
  logic        z_q;

  logic        use_sign;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] acc_next;
  logic [63:0] prod;

  // Signed handling only applies to the long form; plain MUL low word is
  // identical for signed and unsigned operands. -0x80000000 wraps to itself,
  // which is the correct unsigned magnitude.
  assign use_sign = bus.is_signed & bus.is_long;
  assign mag_a    = (use_sign && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
  assign mag_b    = (use_sign && bus.b[31]) ? (32'd0 - bus.b) : bus.b;

  // The last iteration's partial sum feeds the result registers directly,
  // so the product is captured on the same edge that enters DONE.
  assign acc_next = acc + (mplier[0] ? mcand : 64'd0);
  assign prod     = neg_q ? (64'd0 - acc_next) : acc_next;

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result_lo = lo_q;
  assign bus.result_hi = hi_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_z    = z_q;

  // Control FSM, shift-add datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= 6'd0;
      acc    <= 64'd0;
      mcand  <= 64'd0;
      mplier <= 32'd0;
      long_q <= 1'b0;
      neg_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      lo_q   <= 32'd0;
      hi_q   <= 32'd0;
      n_q    <= 1'b0;
      z_q    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mcand  <= {32'd0, mag_a};
            mplier <= mag_b;
            acc    <= 64'd0;
            count  <= 6'd0;
            long_q <= bus.is_long;
            neg_q  <= use_sign & (bus.a[31] ^ bus.b[31]);
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 6'd1;
          if (count == 6'd31) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
            lo_q   <= prod[31:0];
            hi_q   <= long_q ? prod[63:32] : 32'd0;
            n_q    <= long_q ? prod[63] : prod[31];
            z_q    <= long_q ? (prod == 64'd0) : (prod[31:0] == 32'd0);
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: the driver pushes the hand-computed product
// and due cycle for each accepted multiply; a monitor pops and compares on
// every done pulse.
module tb_mul_unit;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        n;
    logic        z;
    int          due;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];

  mul_unit_if bus();

  mul_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index, incremented on each rising edge.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: busy/done exclusivity every cycle, scoreboard compare on done.
  always @(negedge clk) begin
    if (bus.busy || bus.done)
      check("busy_done_exclusive", 64'(bus.busy & bus.done), 64'd0);
    if (bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", 64'(cyc), 64'(e.due));
        check("result_lo", 64'(bus.result_lo), 64'(e.lo));
        check("result_hi", 64'(bus.result_hi), 64'(e.hi));
        check("flag_n", 64'(bus.flag_n), 64'(e.n));
        check("flag_z", 64'(bus.flag_z), 64'(e.z));
      end
    end
  end

  // Issues one multiply at the current cycle T and returns at T+33. Operands
  // and mode are scrambled after acceptance to show they are latched.
  task automatic issue(input logic lng, input logic sgn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lo, input logic [31:0] hi,
                       input logic n, input logic z);
    int t;
    t = cyc;
    bus.start     = 1'b1;
    bus.is_long   = lng;
    bus.is_signed = sgn;
    bus.a         = a;
    bus.b         = b;
    sb.push_back('{lo, hi, n, z, t + 33});
    tick();
    bus.start     = 1'b0;
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.is_long   = ~lng;
    bus.is_signed = ~sgn;
    check("busy_first", 64'(bus.busy), 64'd1);
    while (cyc < t + 32) tick();
    check("busy_last", 64'(bus.busy), 64'd1);
    tick();
    check("busy_at_done", 64'(bus.busy), 64'd0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_lo"},   64'(bus.result_lo), 64'd0);
    check({tag, "_hi"},   64'(bus.result_hi), 64'd0);
    check({tag, "_n"},    64'(bus.flag_n), 64'd0);
    check({tag, "_z"},    64'(bus.flag_z), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.start = 1'b0;
    bus.is_long = 1'b0;
    bus.is_signed = 1'b0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    tick();
    tick();
    check_cleared("reset");
    reset = 1'b0;
    tick();

    // lng sgn a b -> lo hi n z
    issue(0, 0, 32'd7,        32'd6,        32'h0000002A, 32'h00000000, 0, 0);
    issue(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1, 0);
    issue(1, 1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFF, 1, 0);
    issue(1, 1, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 0, 0);
    issue(0, 0, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000000, 0, 1);
    tick();
    tick();
    issue(1, 0, 32'h80000000, 32'h00000002, 32'h00000000, 32'h00000001, 0, 0);
    issue(1, 1, 32'h00000003, 32'hFFFFFFFB, 32'hFFFFFFF1, 32'hFFFFFFFF, 1, 0);
    issue(0, 1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h00000000, 1, 0);
    issue(1, 0, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 0, 1);
    issue(0, 0, 32'h12345678, 32'h00000010, 32'h23456780, 32'h00000000, 0, 0);
    tick();

    // Start re-pulsed mid-run with new operands must be ignored.
    t = cyc;
    bus.start = 1'b1; bus.is_long = 1'b0; bus.is_signed = 1'b0;
    bus.a = 32'd100; bus.b = 32'd200;
    sb.push_back('{32'h00004E20, 32'h0, 1'b0, 1'b0, t + 33});
    tick();
    bus.start = 1'b0;
    while (cyc < t + 5) tick();
    bus.start = 1'b1; bus.is_long = 1'b1; bus.a = 32'd1; bus.b = 32'd1;
    tick();
    bus.start = 1'b0;
    while (cyc < t + 33) tick();
    check("held_lo", 64'(bus.result_lo), 64'h4E20);
    tick();
    tick();
    check("held_after_done_lo", 64'(bus.result_lo), 64'h4E20);

    // Reset mid-run aborts with no done pulse and clears outputs.
    t = cyc;
    bus.start = 1'b1; bus.is_long = 1'b1; bus.is_signed = 1'b0;
    bus.a = 32'd9; bus.b = 32'd9;
    tick();
    bus.start = 1'b0;
    while (cyc < t + 10) tick();
    reset = 1'b1;
    tick();
    check_cleared("abort");
    reset = 1'b0;
    repeat (40) tick();

    // Start coincident with reset is discarded.
    reset = 1'b1;
    bus.start = 1'b1;
    tick();
    reset = 1'b0;
    bus.start = 1'b0;
    tick();
    check("start_with_reset_busy", 64'(bus.busy), 64'd0);
    repeat (40) tick();

    issue(1, 1, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000006, 32'h00000000, 0, 0);
    repeat (3) tick();

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
